// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised and majority-voted input, optional parity,
// one or two stop bits, break detection and a valid/ready output with sticky overrun.
module uart_rx_cfg #(
  parameter int FCLK        = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk50m,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_idle
);

  localparam int DIV = FCLK / BAUD;
  localparam int MID = DIV / 2;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = 4;

  if (DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_param_err
    $error("uart_rx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_q_reg;
  logic [1:0]             samp_reg;
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_err_reg, par_err_next;
  logic                   frm_err_reg, frm_err_next;
  logic                   one_seen_reg, one_seen_next;
  logic                   commit;
  logic                   frm_fin, brk_fin;

  logic [DATA_BITS-1:0]   data_out_reg;
  logic                   valid_reg, par_out_reg, frm_out_reg, brk_out_reg;
  logic                   overrun_reg, idle_reg;

  logic rx_s, fall, vote, mid_tick, handshake;

  assign rx_s      = sync_reg[SYNC_STAGES-1];
  assign fall      = rx_q_reg & ~rx_s;
  // Majority of the current sample and the two before it (cycles MID-2..MID).
  assign vote      = (rx_s & samp_reg[0]) | (rx_s & samp_reg[1]) | (samp_reg[0] & samp_reg[1]);
  assign mid_tick  = (cnt_reg == CW'(MID));
  assign handshake = valid_reg & rx_ready;
  assign frm_fin   = frm_err_reg | ~vote;
  assign brk_fin   = ~(one_seen_reg | vote);

  always_ff @(posedge clk50m) begin
    if (rst) begin
      sync_reg <= '1;
      rx_q_reg <= 1'b1;
      samp_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
      rx_q_reg <= rx_s;
      samp_reg <= {samp_reg[0], rx_s};
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      par_err_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      one_seen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      par_err_reg  <= par_err_next;
      frm_err_reg  <= frm_err_next;
      one_seen_reg <= one_seen_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = (cnt_reg == CW'(DIV - 1)) ? '0 : cnt_reg + 1'b1;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    par_err_next  = par_err_reg;
    frm_err_next  = frm_err_reg;
    one_seen_next = one_seen_reg;
    commit        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Counter sits at 0 so the edge cycle is count 0 of the start bit.
        if (fall) begin
          state_next    = S_START;
          idx_next      = '0;
          par_err_next  = 1'b0;
          frm_err_next  = 1'b0;
          one_seen_next = 1'b0;
        end else begin
          cnt_next = '0;
        end
      end
      S_START: begin
        if (mid_tick) begin
          if (vote) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            state_next = S_DATA;
            idx_next   = '0;
          end
        end
      end
      S_DATA: begin
        if (mid_tick) begin
          shift_next    = {vote, shift_reg[DATA_BITS-1:1]};
          one_seen_next = one_seen_reg | vote;
          if (idx_reg == IW'(DATA_BITS - 1)) begin
            idx_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (mid_tick) begin
          one_seen_next = one_seen_reg | vote;
          par_err_next  = ((^shift_reg) ^ vote) != (PARITY == 1);
          idx_next      = '0;
          state_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (mid_tick) begin
          one_seen_next = one_seen_reg | vote;
          frm_err_next  = frm_fin;
          if (idx_reg == IW'(STOP_BITS - 1)) begin
            commit     = 1'b1;
            cnt_next   = '0;
            state_next = brk_fin ? S_BRK_WAIT : S_IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_BRK_WAIT: begin
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A commit lands only when the output slot is free or being emptied this cycle.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      par_out_reg  <= 1'b0;
      frm_out_reg  <= 1'b0;
      brk_out_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      idle_reg     <= 1'b1;
    end else begin
      idle_reg <= (state_next == S_IDLE);
      if (commit && (!valid_reg || handshake)) begin
        data_out_reg <= shift_reg;
        par_out_reg  <= (PARITY != 0) & par_err_reg;
        frm_out_reg  <= frm_fin;
        brk_out_reg  <= brk_fin;
        valid_reg    <= 1'b1;
        if (handshake) overrun_reg <= 1'b0;
      end else if (commit) begin
        overrun_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg   <= 1'b0;
        overrun_reg <= 1'b0;
      end
    end
  end

  assign rx_data       = data_out_reg;
  assign rx_valid      = valid_reg;
  assign rx_parity_err = par_out_reg;
  assign rx_frame_err  = frm_out_reg;
  assign rx_break      = brk_out_reg;
  assign rx_overrun    = overrun_reg;
  assign rx_idle       = idle_reg;

endmodule
